// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline: data word and the MEM-stage sequencer state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } memstate_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: tracks the reserved address and invalidates it on
// SC completion, a local store to the same address, or a coherence snoop.
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ll_done,
    input  logic              sc_done,
    input  logic              st_done,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              link_valid,
    output logic              addr_match,
    output logic              snoop_hit
);

    logic [ADDR_W-1:0] link_addr;

    assign addr_match = link_valid & (link_addr == addr);
    assign snoop_hit  = snoop_inv & (snoop_addr == link_addr);

    // An LL completing wins over a snoop that lands in the same cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (ll_done) begin
            link_valid <= 1'b1;
            link_addr  <= addr;
        end else if (sc_done | (st_done & (link_addr == addr)) | snoop_hit) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: issues dmem requests for the EX/MEM instruction, stalls
// until dhit, and owns the served flag, sticky halt and stall-cycle counter.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              memRd_MEM,
    input  logic              memWr_MEM,
    input  logic              datomic_MEM,
    input  logic              halt_MEM,
    input  logic [ADDR_W-1:0] addr_MEM,
    input  logic              advance,
    input  logic              dhit,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic              mem_stall,
    output logic              sc_result,
    output logic              link_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    memstate_t state, state_nxt;

    logic served;
    logic sc_hold;
    logic is_rd, is_wr;
    logic addr_match, snoop_hit;
    logic sc_fail, mem_op, active, complete;
    logic ll_done, sc_done, st_done;

    // A load+store combination is illegal and is handled as a load.
    assign is_rd = memRd_MEM;
    assign is_wr = memWr_MEM & ~memRd_MEM;

    assign sc_fail = datomic_MEM & memWr_MEM & ~(addr_match & ~snoop_hit);

    // NOTE: nRST gates the request so REN/WEN drop the instant reset asserts,
    // even while the EX/MEM latch still presents a memory instruction.
    assign mem_op = nRST & (memRd_MEM | memWr_MEM) & ~halted & ~served & ~sc_fail;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        unique case (state)
            IDLE: begin
                active = mem_op;
                if (mem_op && !dhit) state_nxt = REQ;
            end
            REQ: begin
                active = 1'b1;
                if (dhit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign complete  = active & dhit;
    assign ll_done   = complete & is_rd & datomic_MEM;
    assign sc_done   = complete & is_wr & datomic_MEM;
    assign st_done   = complete & is_wr & ~datomic_MEM;

    assign dmemREN   = active & is_rd;
    assign dmemWEN   = active & is_wr;
    assign dmemaddr  = addr_MEM;
    assign mem_stall = active & ~dhit;
    assign sc_result = sc_done | (served & sc_hold);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            served       <= 1'b0;
            sc_hold      <= 1'b0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                served  <= 1'b0;
                sc_hold <= 1'b0;
            end else if (complete) begin
                served  <= 1'b1;
                sc_hold <= sc_done;
            end
            if (halt_MEM && !mem_stall) halted <= 1'b1;
            if (mem_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    link_reg #(
        .ADDR_W (ADDR_W)
    ) u_link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .addr       (addr_MEM),
        .ll_done    (ll_done),
        .sc_done    (sc_done),
        .st_done    (st_done),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .link_valid (link_valid),
        .addr_match (addr_match),
        .snoop_hit  (snoop_hit)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized
// op stream compared against a transaction-level model of the MEM stage.
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              memRd_MEM = 1'b0, memWr_MEM = 1'b0, datomic_MEM = 1'b0, halt_MEM = 1'b0;
    logic [ADDR_W-1:0] addr_MEM = '0;
    logic              advance = 1'b0, dhit = 1'b0, snoop_inv = 1'b0;
    logic [ADDR_W-1:0] snoop_addr = '0;
    logic              dmemREN, dmemWEN, mem_stall, sc_result, link_valid, halted;
    logic [ADDR_W-1:0] dmemaddr;
    logic [CNT_W-1:0]  stall_cycles;

    int passed = 0;
    int total  = 0;

    // Transaction-level model state
    bit          m_link_valid;
    logic [31:0] m_link_addr;
    int          m_stalls;
    bit          m_halted;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .memRd_MEM    (memRd_MEM),
        .memWr_MEM    (memWr_MEM),
        .datomic_MEM  (datomic_MEM),
        .halt_MEM     (halt_MEM),
        .addr_MEM     (addr_MEM),
        .advance      (advance),
        .dhit         (dhit),
        .snoop_inv    (snoop_inv),
        .snoop_addr   (snoop_addr),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .mem_stall    (mem_stall),
        .sc_result    (sc_result),
        .link_valid   (link_valid),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    task automatic clear_inputs();
        memRd_MEM = 0; memWr_MEM = 0; datomic_MEM = 0; halt_MEM = 0;
        advance = 0; dhit = 0; snoop_inv = 0;
    endtask

    task automatic model_reset();
        m_link_valid = 0; m_link_addr = '0; m_stalls = 0; m_halted = 0;
    endtask

    // Expected behaviour of one MEM-stage instruction whose dhit arrives n cycles late.
    task automatic model_op(input bit rd, input bit wr, input bit at, input logic [31:0] a,
                            input int n, output int e_ren, output int e_wen,
                            output int e_stall, output bit e_sc);
        bit is_sc;
        is_sc = at && wr && !rd;
        e_ren = 0; e_wen = 0; e_stall = 0; e_sc = 0;
        if (m_halted || (!rd && !wr)) return;
        if (is_sc && !(m_link_valid && m_link_addr == a)) return;
        e_stall = n;
        if (rd) e_ren = n + 1; else e_wen = n + 1;
        m_stalls = (m_stalls + n > CNT_MAX) ? CNT_MAX : m_stalls + n;
        if (rd && at) begin
            m_link_valid = 1; m_link_addr = a;
        end else if (is_sc) begin
            m_link_valid = 0; e_sc = 1;
        end else if (wr && a == m_link_addr) begin
            m_link_valid = 0;
        end
    endtask

    // Drives one instruction, dhit/advance on cycle n, and records what the DUT did.
    task automatic run_op(input bit rd, input bit wr, input bit at, input logic [31:0] a,
                          input int n, output int ren_n, output int wen_n,
                          output int stall_n, output bit sc_obs, output logic [31:0] addr_obs);
        memRd_MEM = rd; memWr_MEM = wr; datomic_MEM = at; addr_MEM = a;
        advance = 0; dhit = 0;
        ren_n = 0; wen_n = 0; stall_n = 0; sc_obs = 0; addr_obs = '0;
        for (int c = 0; c <= n; c++) begin
            if (c == n) begin dhit = 1; advance = 1; end
            @(negedge CLK);
            ren_n   += int'(dmemREN);
            wen_n   += int'(dmemWEN);
            stall_n += int'(mem_stall);
            if (c == n) begin sc_obs = sc_result; addr_obs = dmemaddr; end
            @(posedge CLK); #1;
        end
        clear_inputs();
    endtask

    task automatic do_snoop(input logic [31:0] a);
        snoop_inv = 1; snoop_addr = a; advance = 1;
        if (a == m_link_addr) m_link_valid = 0;
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    // Runs model and DUT for one op and compares every observable.
    task automatic check_op(input string name, input bit rd, input bit wr, input bit at,
                            input logic [31:0] a, input int n);
        int e_ren, e_wen, e_stall, ren_n, wen_n, stall_n;
        bit e_sc, sc_obs;
        logic [31:0] addr_obs;
        model_op(rd, wr, at, a, n, e_ren, e_wen, e_stall, e_sc);
        run_op(rd, wr, at, a, n, ren_n, wen_n, stall_n, sc_obs, addr_obs);
        total++; if (ren_n !== e_ren) $display("FAIL %s ren_cycles got=%0d exp=%0d", name, ren_n, e_ren); else passed++;
        total++; if (wen_n !== e_wen) $display("FAIL %s wen_cycles got=%0d exp=%0d", name, wen_n, e_wen); else passed++;
        total++; if (stall_n !== e_stall) $display("FAIL %s stall_cycles_seen got=%0d exp=%0d", name, stall_n, e_stall); else passed++;
        total++; if (sc_obs !== e_sc) $display("FAIL %s sc_result got=%0b exp=%0b", name, sc_obs, e_sc); else passed++;
        total++; if (addr_obs !== a) $display("FAIL %s dmemaddr got=%h exp=%h", name, addr_obs, a); else passed++;
        total++; if (link_valid !== m_link_valid) $display("FAIL %s link_valid got=%0b exp=%0b", name, link_valid, m_link_valid); else passed++;
        total++; if (stall_cycles !== CNT_W'(m_stalls)) $display("FAIL %s stall_counter got=%0d exp=%0d", name, stall_cycles, m_stalls); else passed++;
    endtask

    task automatic test_reset();
        model_reset();
        clear_inputs();
        memRd_MEM = 1; addr_MEM = 32'h100;
        #2;
        total++; if ({dmemREN, dmemWEN, mem_stall, sc_result, link_valid, halted} !== 6'b0)
            $display("FAIL reset outputs got=%b exp=000000", {dmemREN, dmemWEN, mem_stall, sc_result, link_valid, halted}); else passed++;
        total++; if (stall_cycles !== '0) $display("FAIL reset stall_counter got=%0d exp=0", stall_cycles); else passed++;
        clear_inputs();
        @(negedge CLK); nRST = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        check_op("load_0x100_wait3", 1, 0, 0, 32'h100, 3);
        for (int i = 0; i < 3; i++)
            check_op("load_rand", 1, 0, 0, $urandom & 32'hFFFC, $urandom_range(0, 4));
    endtask

    task automatic test_store();
        check_op("store_0x200_hit", 0, 1, 0, 32'h200, 0);
        check_op("store_rand", 0, 1, 0, $urandom & 32'hFFFC, $urandom_range(1, 3));
        check_op("illegal_rd_wr", 1, 1, 0, 32'h300, 1);
    endtask

    task automatic test_ll_sc();
        check_op("ll_0x40", 1, 0, 1, 32'h40, $urandom_range(0, 2));
        check_op("sc_0x40_ok", 0, 1, 1, 32'h40, $urandom_range(0, 2));
        check_op("sc_0x40_nolink", 0, 1, 1, 32'h40, 1);
        check_op("ll_0x80", 1, 0, 1, 32'h80, 0);
        check_op("store_0x80_kills", 0, 1, 0, 32'h80, 0);
        check_op("sc_0x80_fail", 0, 1, 1, 32'h80, 0);
    endtask

    task automatic test_snoop_sc();
        check_op("ll_0x40_pre_snoop", 1, 0, 1, 32'h40, 1);
        do_snoop(32'h44);
        total++; if (link_valid !== 1'b1) $display("FAIL snoop_other_addr link_valid got=%0b exp=1", link_valid); else passed++;
        do_snoop(32'h40);
        total++; if (link_valid !== 1'b0) $display("FAIL snoop_hit link_valid got=%0b exp=0", link_valid); else passed++;
        check_op("sc_after_snoop", 0, 1, 1, 32'h40, 1);
        // LL completing alongside a snoop of the same address keeps the link.
        memRd_MEM = 1; datomic_MEM = 1; addr_MEM = 32'h40; dhit = 1; advance = 1;
        snoop_inv = 1; snoop_addr = 32'h40;
        @(posedge CLK); #1;
        clear_inputs();
        m_link_valid = 1; m_link_addr = 32'h40;
        total++; if (link_valid !== 1'b1) $display("FAIL ll_beats_snoop link_valid got=%0b exp=1", link_valid); else passed++;
    endtask

    task automatic test_served();
        int ren_n, wen_n, sc_n;
        check_op("ll_0x180", 1, 0, 1, 32'h180, 0);
        for (int k = 0; k < 2; k++) begin
            memRd_MEM = (k == 0); memWr_MEM = (k == 1); datomic_MEM = (k == 1);
            addr_MEM = 32'h180;
            ren_n = 0; wen_n = 0; sc_n = 0;
            for (int c = 0; c < 3; c++) begin
                dhit = (c == 0); advance = (c == 2);
                @(negedge CLK);
                ren_n += int'(dmemREN); wen_n += int'(dmemWEN); sc_n += int'(sc_result);
                @(posedge CLK); #1;
            end
            clear_inputs();
            if (k == 1) m_link_valid = 0;
            total++; if (ren_n + wen_n !== 1) $display("FAIL served_%0d requests got=%0d exp=1", k, ren_n + wen_n); else passed++;
            total++; if (sc_n !== (k == 1 ? 3 : 0)) $display("FAIL served_%0d sc_held got=%0d exp=%0d", k, sc_n, (k == 1 ? 3 : 0)); else passed++;
        end
        total++; if (link_valid !== m_link_valid) $display("FAIL served link_valid got=%0b exp=%0b", link_valid, m_link_valid); else passed++;
        check_op("after_served_load", 1, 0, 0, 32'h180, 1);
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        logic [31:0] a;
        int kind, n;
        pool[0] = 32'h40; pool[1] = 32'h80; pool[2] = 32'h100; pool[3] = 32'h200;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            a = pool[$urandom_range(0, 3)];
            n = $urandom_range(0, 3);
            case (kind)
                0: check_op("rand_load", 1, 0, 0, a, n);
                1: check_op("rand_store", 0, 1, 0, a, n);
                2: check_op("rand_ll", 1, 0, 1, a, n);
                3: check_op("rand_sc", 0, 1, 1, a, n);
                4: begin
                    do_snoop(a);
                    total++; if (link_valid !== m_link_valid) $display("FAIL rand_snoop link_valid got=%0b exp=%0b", link_valid, m_link_valid); else passed++;
                end
                default: check_op("rand_idle", 0, 0, 0, a, n);
            endcase
        end
    endtask

    task automatic test_saturate();
        check_op("long_load", 1, 0, 0, 32'h500, CNT_MAX + 20);
        check_op("load_at_sat", 1, 0, 0, 32'h504, 2);
    endtask

    task automatic test_reset_mid_req();
        memRd_MEM = 1; addr_MEM = 32'h600;
        repeat (2) begin @(posedge CLK); #1; end
        @(negedge CLK);
        total++; if (dmemREN !== 1'b1) $display("FAIL mid_req pre_reset ren got=%0b exp=1", dmemREN); else passed++;
        #2 nRST = 0;
        #1;
        model_reset();
        total++; if ({dmemREN, mem_stall, link_valid} !== 3'b000) $display("FAIL mid_req async_drop got=%b exp=000", {dmemREN, mem_stall, link_valid}); else passed++;
        total++; if (stall_cycles !== '0) $display("FAIL mid_req stall_counter got=%0d exp=0", stall_cycles); else passed++;
        clear_inputs();
        @(posedge CLK); #1 nRST = 1;
        @(posedge CLK); #1;
        check_op("post_reset_load", 1, 0, 0, 32'h600, 1);
    endtask

    task automatic test_halt();
        memRd_MEM = 1; addr_MEM = 32'h700; halt_MEM = 1;
        @(posedge CLK); #1;
        total++; if (halted !== 1'b0) $display("FAIL halt_while_stalled halted got=%0b exp=0", halted); else passed++;
        dhit = 1; advance = 1;
        @(posedge CLK); #1;
        clear_inputs();
        m_stalls = (m_stalls + 1 > CNT_MAX) ? CNT_MAX : m_stalls + 1;
        m_halted = 1;
        total++; if (halted !== 1'b1) $display("FAIL halt_set halted got=%0b exp=1", halted); else passed++;
        check_op("load_after_halt", 1, 0, 0, 32'h100, 2);
        check_op("store_after_halt", 0, 1, 0, 32'h200, 0);
        total++; if (halted !== 1'b1) $display("FAIL halt_sticky halted got=%0b exp=1", halted); else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_ll_sc();
        test_snoop_sc();
        test_served();
        test_random();
        test_saturate();
        test_reset_mid_req();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
